safe_lock_ctrl: RTL and testbench

//  Parametrised safe-lock controller: accepts a stream of DW-bit digits over valid/ready and compares each

---
 rtl/safe_lock_pkg.sv | 20 ++
 rtl/safe_lock_timer.sv | 28 ++
 rtl/safe_lock_ctrl.sv | 137 +++++++++++++
 tb/tb_safe_lock_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/safe_lock_pkg.sv
// Shared types and width helpers for the safe-lock controller.
package safe_lock_pkg;

  typedef enum logic [2:0] {
    LOCKED   = 3'd0,
    CHECK    = 3'd1,
    UNLOCKED = 3'd2,
    PROGRAM  = 3'd3,
    LOCKOUT  = 3'd4
  } lock_state_t;

  function automatic int code_width(input int dw, input int digits);
    return dw * digits;
  endfunction

  function automatic int count_width(input int digits);
    return $clog2(digits + 1);
  endfunction

endpackage

// File: rtl/safe_lock_timer.sv
// Lockout down-counter: load arms it, expired pulses for one cycle on its final count.
module safe_lock_timer #(
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  output logic expired
);

  localparam int TW = $clog2(LOCKOUT_CYCLES + 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rstn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= TW'(LOCKOUT_CYCLES);
    end else if (cnt != '0) begin
      cnt <= cnt - TW'(1);
    end
  end

  // Firing on the last count lets the FSM leave after exactly LOCKOUT_CYCLES cycles.
  assign expired = (cnt == TW'(1));

endmodule

// File: rtl/safe_lock_ctrl.sv
// Safe-lock controller: collects MSD-first digit entries, judges them against a
// reprogrammable code, and enforces a timed lockout after repeated failures.
module safe_lock_ctrl
  import safe_lock_pkg::*;
#(
  parameter int DW             = 4,
  parameter int DIGITS         = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter logic [DW*DIGITS-1:0] DEFAULT_CODE = 'h1234
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DW-1:0]                  in_data,
  input  logic                           relock,
  input  logic                           prog_req,
  output logic                           unlocked,
  output logic                           lockout,
  output logic                           result_valid,
  output logic                           result_ok,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left
);

  localparam int CODE_W = code_width(DW, DIGITS);
  localparam int CNT_W  = count_width(DIGITS);
  localparam int TL_W   = $clog2(MAX_TRIES + 1);

  lock_state_t       state, state_nx;
  logic [CNT_W-1:0]  dcnt;
  logic [CODE_W-1:0] entry, shadow, code;
  logic [TL_W-1:0]   fails;
  logic              accept, entry_full, last_digit, match, final_fail;
  logic              timer_load, timer_expired;

  function automatic logic [CODE_W-1:0] shift_digit(input logic [CODE_W-1:0] r,
                                                    input logic [DW-1:0]     d);
    logic [CODE_W+DW-1:0] w;
    w = {r, d};
    return w[CODE_W-1:0];
  endfunction

  assign entry_full = (dcnt == CNT_W'(DIGITS));
  assign last_digit = (dcnt == CNT_W'(DIGITS - 1));
  assign match      = (entry == code);
  assign final_fail = (fails == TL_W'(MAX_TRIES - 1));
  // A full entry holds off further digits for the cycle before CHECK.
  assign in_ready   = !rstn && (((state == LOCKED) && !entry_full) || (state == PROGRAM));
  assign accept     = in_valid && in_ready;
  assign unlocked   = (state == UNLOCKED);
  assign lockout    = (state == LOCKOUT);
  assign tries_left = TL_W'(MAX_TRIES) - fails;

  safe_lock_timer #(.LOCKOUT_CYCLES(LOCKOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rstn    (rstn),
    .load    (timer_load),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rstn) state <= LOCKED;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    timer_load = 1'b0;
    case (state)
      LOCKED:   if (entry_full) state_nx = CHECK;
      CHECK: begin
        if (match) begin
          state_nx = UNLOCKED;
        end else if (final_fail) begin
          state_nx   = LOCKOUT;
          timer_load = 1'b1;
        end else begin
          state_nx = LOCKED;
        end
      end
      UNLOCKED: begin
        if (relock)        state_nx = LOCKED;
        else if (prog_req) state_nx = PROGRAM;
      end
      PROGRAM:  if (relock || (accept && last_digit)) state_nx = LOCKED;
      LOCKOUT:  if (timer_expired) state_nx = LOCKED;
      default:  state_nx = LOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      dcnt         <= '0;
      fails        <= '0;
      code         <= DEFAULT_CODE;
      result_valid <= 1'b0;
      result_ok    <= 1'b0;
    end else begin
      result_valid <= (state == CHECK);
      result_ok    <= (state == CHECK) && match;
      case (state)
        LOCKED: begin
          if (entry_full)  dcnt <= '0;
          else if (accept) dcnt <= dcnt + CNT_W'(1);
        end
        CHECK: begin
          if (match)                           fails <= '0;
          else if (fails != TL_W'(MAX_TRIES))  fails <= fails + TL_W'(1);
        end
        PROGRAM: begin
          // relock wins over a final digit arriving in the same cycle.
          if (relock) begin
            dcnt <= '0;
          end else if (accept) begin
            if (last_digit) begin
              code <= shift_digit(shadow, in_data);
              dcnt <= '0;
            end else begin
              dcnt <= dcnt + CNT_W'(1);
            end
          end
        end
        LOCKOUT:  if (timer_expired) fails <= '0;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      if (state == LOCKED) entry  <= shift_digit(entry, in_data);
      else                 shadow <= shift_digit(shadow, in_data);
    end
  end

endmodule

// File: tb/tb_safe_lock_ctrl.sv
// Directed bench for safe_lock_ctrl at default parameters.
module tb_safe_lock_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = '0;
  logic       relock = 1'b0;
  logic       prog_req = 1'b0;
  logic       unlocked, lockout, result_valid, result_ok;
  logic [1:0] tries_left;

  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  safe_lock_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .relock       (relock),
    .prog_req     (prog_req),
    .unlocked     (unlocked),
    .lockout      (lockout),
    .result_valid (result_valid),
    .result_ok    (result_ok),
    .tries_left   (tries_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL [%s] %s: got %0h expected %0h", phase, tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_unlocked", 32'(unlocked), 0);
    chk("rst_lockout", 32'(lockout), 0);
    chk("rst_result_valid", 32'(result_valid), 0);
    chk("rst_result_ok", 32'(result_ok), 0);
    chk("rst_tries_left", 32'(tries_left), 3);
    rstn = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);
  endtask

  // Presents one digit after an optional idle gap and returns 1ns after its accepting edge.
  task automatic send_digit(input logic [3:0] d, input int gap);
    int n;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) tick();
    end
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) chk("ready_wait", 32'(in_ready), 1);
    tick();
  endtask

  task automatic enter_code(input logic [15:0] c, input int maxgap);
    for (int i = 0; i < 4; i++) begin
      send_digit(c[15-4*i -: 4], (i > 0 && maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end
    in_valid = 1'b0;
  endtask

  task automatic expect_result(input logic ok, input logic unl, input logic lo, input int tries);
    chk("full_in_ready", 32'(in_ready), 0);
    tick();
    chk("check_result_valid", 32'(result_valid), 0);
    chk("check_in_ready", 32'(in_ready), 0);
    tick();
    chk("result_valid", 32'(result_valid), 1);
    chk("result_ok", 32'(result_ok), 32'(ok));
    chk("unlocked", 32'(unlocked), 32'(unl));
    chk("lockout", 32'(lockout), 32'(lo));
    chk("tries_left", 32'(tries_left), 32'(tries));
  endtask

  task automatic pulse_relock();
    relock = 1'b1;
    tick();
    relock = 1'b0;
  endtask

  task automatic pulse_prog();
    prog_req = 1'b1;
    tick();
    prog_req = 1'b0;
  endtask

  initial begin
    int n;

    phase = "reset";
    do_reset();

    phase = "unlock";
    enter_code(16'h1234, 0);
    expect_result(1'b1, 1'b1, 1'b0, 3);
    tick();
    chk("pulse_end", 32'(result_valid), 0);
    chk("unlocked_ready", 32'(in_ready), 0);
    pulse_relock();
    chk("relocked", 32'(unlocked), 0);
    chk("relocked_ready", 32'(in_ready), 1);

    phase = "lockout";
    enter_code(16'h1235, 0);
    expect_result(1'b0, 1'b0, 1'b0, 2);
    enter_code(16'h1235, 0);
    expect_result(1'b0, 1'b0, 1'b0, 1);
    enter_code(16'h1235, 0);
    expect_result(1'b0, 1'b0, 1'b1, 0);
    prog_req = 1'b1;
    relock   = 1'b1;
    n = 0;
    while (lockout === 1'b1 && n < 100) begin
      n++;
      if (n == 8) begin
        chk("lockout_tries", 32'(tries_left), 0);
        chk("lockout_ready", 32'(in_ready), 0);
      end
      tick();
    end
    prog_req = 1'b0;
    relock   = 1'b0;
    chk("lockout_cycles", 32'(n), 16);
    chk("after_lockout_tries", 32'(tries_left), 3);
    chk("after_lockout_ready", 32'(in_ready), 1);
    chk("after_lockout_unlocked", 32'(unlocked), 0);

    phase = "fail_then_ok";
    enter_code(16'h1235, 0);
    expect_result(1'b0, 1'b0, 1'b0, 2);
    enter_code(16'h1234, 0);
    expect_result(1'b1, 1'b1, 1'b0, 3);

    phase = "program";
    pulse_prog();
    chk("prog_unlocked", 32'(unlocked), 0);
    chk("prog_ready", 32'(in_ready), 1);
    enter_code(16'h9876, 0);
    chk("prog_done_ready", 32'(in_ready), 1);
    tick();
    chk("prog_no_result", 32'(result_valid), 0);
    enter_code(16'h1234, 0);
    expect_result(1'b0, 1'b0, 1'b0, 2);
    enter_code(16'h9876, 0);
    expect_result(1'b1, 1'b1, 1'b0, 3);

    phase = "prog_abort";
    do_reset();
    enter_code(16'h1234, 0);
    expect_result(1'b1, 1'b1, 1'b0, 3);
    pulse_prog();
    send_digit(4'h5, 0);
    send_digit(4'h5, 0);
    in_valid = 1'b0;
    pulse_relock();
    chk("abort_unlocked", 32'(unlocked), 0);
    chk("abort_ready", 32'(in_ready), 1);
    enter_code(16'h1234, 0);
    expect_result(1'b1, 1'b1, 1'b0, 3);

    phase = "relock_final_digit";
    pulse_prog();
    send_digit(4'h5, 0);
    send_digit(4'h5, 0);
    send_digit(4'h5, 0);
    in_data = 4'h5;
    relock  = 1'b1;
    tick();
    in_valid = 1'b0;
    relock   = 1'b0;
    chk("race_unlocked", 32'(unlocked), 0);
    enter_code(16'h1234, 0);
    expect_result(1'b1, 1'b1, 1'b0, 3);

    phase = "relock_and_prog";
    relock   = 1'b1;
    prog_req = 1'b1;
    tick();
    relock   = 1'b0;
    prog_req = 1'b0;
    chk("both_unlocked", 32'(unlocked), 0);
    enter_code(16'h1234, 0);
    expect_result(1'b1, 1'b1, 1'b0, 3);
    pulse_relock();

    phase = "reset_mid_entry";
    send_digit(4'h1, 0);
    send_digit(4'h2, 0);
    in_valid = 1'b0;
    do_reset();
    enter_code(16'h1234, 0);
    expect_result(1'b1, 1'b1, 1'b0, 3);
    pulse_relock();

    phase = "reset_mid_lockout";
    for (int k = 0; k < 3; k++) begin
      enter_code(16'h1235, 0);
      expect_result(1'b0, 1'b0, (k == 2), 2 - k);
    end
    repeat (5) tick();
    chk("mid_lockout", 32'(lockout), 1);
    do_reset();
    enter_code(16'h1234, 3);
    expect_result(1'b1, 1'b1, 1'b0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
